// File: rtl/seg_scan_driver.sv
// Eight-digit BCD shift buffer time-multiplexed onto a shared 7-segment bus.
// A prescaled scan index selects one digit per dwell; cathodes and anodes are registered.
module seg_scan_driver #(
    parameter int unsigned DIV  = 100000,
    parameter int unsigned NDIG = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] din,
    input  logic       din_valid,
    input  logic       clr,
    input  logic       blank_lz,
    output logic [6:0] cn,
    output logic [7:0] an,
    output logic [3:0] ndig,
    output logic       err
);

    localparam int unsigned PW = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [3:0] NDIG_MAX = 4'(NDIG);

    logic [3:0]    buf_q [NDIG];
    logic [3:0]    buf_d [NDIG];
    logic [3:0]    ndig_q, ndig_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    cn_q, cn_d;
    logic          err_q, err_d;
    logic          tick;
    logic          blank;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'h7F;
        endcase
    endfunction

    always_comb begin
        buf_d  = buf_q;
        ndig_d = ndig_q;
        err_d  = 1'b0;
        if (clr) begin
            for (int i = 0; i < NDIG; i++) buf_d[i] = 4'd0;
            ndig_d = 4'd0;
        end else if (din_valid) begin
            if (din > 4'd9) begin
                err_d = 1'b1;
            end else begin
                for (int i = NDIG - 1; i > 0; i--) buf_d[i] = buf_q[i-1];
                buf_d[0] = din;
                if (ndig_q != NDIG_MAX) ndig_d = ndig_q + 4'd1;
            end
        end

        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = tick ? idx_q + 3'd1 : idx_q;

        // Position 0 is never blanked so an empty buffer still shows "0".
        blank = blank_lz && ({1'b0, idx_q} >= ndig_q) && (idx_q != 3'd0);
        an_d  = ~(8'b1 << idx_q);
        cn_d  = blank ? 7'h7F : seg(buf_q[idx_q]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the digit buffer is only eight nibbles of flops, so it is reset
            // explicitly; a RAM-style array would normally be left unreset.
            for (int i = 0; i < NDIG; i++) buf_q[i] <= 4'd0;
            ndig_q  <= 4'd0;
            presc_q <= '0;
            idx_q   <= 3'd0;
            an_q    <= 8'hFF;
            cn_q    <= 7'h7F;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            buf_q   <= buf_d;
            ndig_q  <= ndig_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            cn_q    <= cn_d;
            err_q   <= err_d;
        end
    end

    assign cn   = cn_q;
    assign an   = an_q;
    assign ndig = ndig_q;
    assign err  = err_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIV=4: display vectors from a table,
// hand-written sequences for reset, scan wrap, saturation, error and clear.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din;
    logic       din_valid;
    logic       clr;
    logic       blank_lz;
    logic [6:0] cn;
    logic [7:0] an;
    logic [3:0] ndig;
    logic       err;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S5 = 7'b0010010, S9 = 7'b0010000,
                           DARK = 7'h7F;

    typedef struct {
        int         phase;
        logic       blank;
        logic [7:0] an_target;
        logic [6:0] cn_exp;
    } disp_vec_t;

    disp_vec_t vecs[16];

    seg_scan_driver #(.DIV(4), .NDIG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .clr       (clr),
        .blank_lz  (blank_lz),
        .cn        (cn),
        .an        (an),
        .ndig      (ndig),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    // One rising edge; returns at the following falling edge where outputs are sampled.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic enter(input logic [3:0] d);
        din       = d;
        din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
    endtask

    task automatic wait_an(input logic [7:0] target, input string name);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (an !== target && n < 40);
        if (an !== target) begin
            n_total++;
            $display("FAIL %s: timeout waiting for an=%h, got %h", name, target, an);
        end
    endtask

    task automatic run_phase(input int p);
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].phase == p) begin
                blank_lz = vecs[i].blank;
                wait_an(vecs[i].an_target, $sformatf("disp%0d_%0d", p, i));
                check($sformatf("disp%0d_%0d_cn", p, i), 32'(cn), 32'(vecs[i].cn_exp));
            end
        end
    endtask

    initial begin
        // After entering 1,2,3: buf[2..0] = 1,2,3
        vecs[0]  = '{1, 1'b1, 8'hFE, S3};
        vecs[1]  = '{1, 1'b1, 8'hFD, S2};
        vecs[2]  = '{1, 1'b1, 8'hFB, S1};
        vecs[3]  = '{1, 1'b1, 8'hF7, DARK};
        vecs[4]  = '{1, 1'b1, 8'h7F, DARK};
        vecs[5]  = '{1, 1'b0, 8'hF7, S0};
        vecs[6]  = '{1, 1'b0, 8'h7F, S0};
        vecs[7]  = '{1, 1'b0, 8'hFE, S3};
        // After entering 1..9: buf[7..0] = 2..9
        vecs[8]  = '{2, 1'b1, 8'h7F, S2};
        vecs[9]  = '{2, 1'b1, 8'hFE, S9};
        vecs[10] = '{2, 1'b1, 8'hBF, S3};
        vecs[11] = '{2, 1'b1, 8'hEF, S5};
        // After simultaneous clr and din_valid
        vecs[12] = '{3, 1'b1, 8'hFE, S0};
        vecs[13] = '{3, 1'b1, 8'hFD, DARK};
        vecs[14] = '{3, 1'b0, 8'hFD, S0};
        vecs[15] = '{3, 1'b1, 8'hFE, S0};

        rst_n = 1'b0; din = 4'd0; din_valid = 1'b0; clr = 1'b0; blank_lz = 1'b1;
        repeat (2) cyc();
        check("rst_an", 32'(an), 32'hFF);
        check("rst_cn", 32'(cn), 32'(DARK));
        check("rst_ndig", 32'(ndig), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // Scan with no input: index held 4 edges per digit, wraps after 32 edges.
        rst_n = 1'b1;
        cyc();
        check("e1_an", 32'(an), 32'hFE);
        check("e1_cn", 32'(cn), 32'(S0));
        repeat (3) cyc();
        check("e4_an", 32'(an), 32'hFE);
        cyc();
        check("e5_an", 32'(an), 32'hFD);
        check("e5_cn", 32'(cn), 32'(DARK));
        repeat (4) cyc();
        check("e9_an", 32'(an), 32'hFB);
        check("e9_cn", 32'(cn), 32'(DARK));
        repeat (23) cyc();
        check("e32_an", 32'(an), 32'h7F);
        cyc();
        check("e33_an", 32'(an), 32'hFE);
        check("e33_cn", 32'(cn), 32'(S0));

        enter(4'd1);
        enter(4'd2);
        enter(4'd3);
        check("ndig3", 32'(ndig), 32'd3);
        check("err_after_entry", 32'(err), 32'd0);
        run_phase(1);

        // Invalid digit: one-cycle err, nothing else changes.
        din = 4'hA; din_valid = 1'b1;
        cyc();
        din_valid = 1'b0;
        check("err_pulse", 32'(err), 32'd1);
        check("err_ndig", 32'(ndig), 32'd3);
        cyc();
        check("err_clear", 32'(err), 32'd0);
        blank_lz = 1'b1;
        wait_an(8'hFE, "err_buf");
        check("err_buf_cn", 32'(cn), 32'(S3));

        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check("clr_ndig", 32'(ndig), 32'd0);
        for (int d = 1; d <= 9; d++) begin
            enter(4'(d));
            if (d == 8) check("ndig8", 32'(ndig), 32'd8);
        end
        check("ndig_sat", 32'(ndig), 32'd8);
        run_phase(2);

        // clr wins over a simultaneous valid strobe.
        din = 4'd5; din_valid = 1'b1; clr = 1'b1;
        cyc();
        din_valid = 1'b0; clr = 1'b0;
        check("clrpri_ndig", 32'(ndig), 32'd0);
        check("clrpri_err", 32'(err), 32'd0);
        run_phase(3);

        // Asynchronous reset mid-dwell at index 5.
        enter(4'd7);
        check("pre_rst_ndig", 32'(ndig), 32'd1);
        blank_lz = 1'b1;
        wait_an(8'hDF, "idx5");
        cyc();
        #2 rst_n = 1'b0;
        #1;
        check("async_an", 32'(an), 32'hFF);
        check("async_cn", 32'(cn), 32'(DARK));
        check("async_ndig", 32'(ndig), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check("rel_an", 32'(an), 32'hFE);
        check("rel_cn", 32'(cn), 32'(S0));
        check("rel_ndig", 32'(ndig), 32'd0);
        repeat (3) cyc();
        check("rel_e4_an", 32'(an), 32'hFE);
        cyc();
        check("rel_e5_an", 32'(an), 32'hFD);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
